// File: rtl/ef_sram_arb_pkg.sv
// ef_sram_arb_pkg
// Shared definitions for the two-requester EF_SRAM_1024x32v2 port arbiter:
// default address/data widths, requester ids, and the command struct that
// carries one granted access from the accept stage into the SRAM pin stage.
package ef_sram_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   // Requester ids; also the value of the response tag bit.
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef struct packed {
      logic                  id;
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_DATA_W-1:0] ben;
   } cmd_t;

endpackage

// File: rtl/ef_sram_rr_arbiter.sv
// ef_sram_rr_arbiter
// Two-way arbiter with burst counter.
//   clk, rst   : clock, synchronous active-high reset (grant forced low in reset)
//   valid[1:0] : request valids, bit 0 = A, bit 1 = B
//   grant[1:0] : one-hot grant, combinational from valid and arbiter state
// Round-robin mode alternates on every tie, so a holder never exceeds a run
// of one grant while the other side waits. Fixed-priority mode gives A every
// tie until A's consecutive-grant count reaches MAX_BURST, then B gets one.
module ef_sram_rr_arbiter
   import ef_sram_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter bit PRIO_A    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   // Arbiter state: id of the last grant and its consecutive-grant count.
   logic       last_grant;
   logic [3:0] burst_cnt;
   logic       cap;

   assign cap = (int'(burst_cnt) >= MAX_BURST);

   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (valid == 2'b11) begin
            if (PRIO_A)
               grant = (last_grant == REQ_A && cap) ? 2'b10 : 2'b01;
            else
               grant = (last_grant == REQ_A) ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
   end

   // A zero count marks "no grant last cycle", so the next grant starts a
   // fresh run at 1 even when it goes to the same requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= REQ_B;
         burst_cnt  <= 4'd0;
      end else if (|grant) begin
         if (grant[1] == last_grant && burst_cnt != 4'd0)
            burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
         else
            burst_cnt <= 4'd1;
         last_grant <= grant[1];
      end else begin
         burst_cnt <= 4'd0;
      end
   end

endmodule

// File: rtl/ef_sram_arbiter.sv
// ef_sram_arbiter
// Shares one EF_SRAM_1024x32v2 port between requesters A and B.
//   UserCLK, RST             : clock, synchronous active-high reset
//   a_req_* / b_req_*        : valid/ready request channels (we, addr, wdata, ben)
//   a_rsp_* / b_rsp_*        : un-stalled one-cycle completion pulse + read data
//   sram_di/ben/ad/en/r_wb   : registered SRAM command pins
//   sram_do                  : SRAM read data, valid the cycle after the command
// Handshake: a request transfers in the cycle where valid and ready are both
// high; ready never rises without its own valid, at most one ready is high,
// and the response follows exactly two cycles after the transfer.
// Pipeline: C0 accept/arbitrate -> C1 SRAM pins (registered) -> C2 response.
module ef_sram_arbiter
   import ef_sram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4,
   parameter bit PRIO_A    = 1'b0
) (
   input  logic              UserCLK,
   input  logic              RST,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   input  logic [DATA_W-1:0] a_req_ben,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_rdata,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   input  logic [DATA_W-1:0] b_req_ben,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_rdata,
   output logic [DATA_W-1:0] sram_di,
   output logic [DATA_W-1:0] sram_ben,
   output logic [ADDR_W-1:0] sram_ad,
   output logic              sram_en,
   output logic              sram_r_wb,
   input  logic [DATA_W-1:0] sram_do
);

   logic [1:0] grant;
   cmd_t       c0_cmd;
   logic       c1_id, c1_we;
   logic       c2_valid, c2_id, c2_we;

   ef_sram_rr_arbiter #(
      .MAX_BURST (MAX_BURST),
      .PRIO_A    (PRIO_A)
   ) u_arb (
      .clk   (UserCLK),
      .rst   (RST),
      .valid ({b_req_valid, a_req_valid}),
      .grant (grant)
   );

   assign a_req_ready = grant[0];
   assign b_req_ready = grant[1];

   always_comb begin
      c0_cmd.id    = grant[1] ? REQ_B : REQ_A;
      c0_cmd.we    = grant[1] ? b_req_we    : a_req_we;
      c0_cmd.addr  = grant[1] ? b_req_addr  : a_req_addr;
      c0_cmd.wdata = grant[1] ? b_req_wdata : a_req_wdata;
      c0_cmd.ben   = grant[1] ? b_req_ben   : a_req_ben;
   end

   // C1 pins and C2 tag pipe. sram_en doubles as the C1 valid bit, so a
   // reset clears both the pins and any tag already headed for C2.
   always_ff @(posedge UserCLK) begin
      if (RST) begin
         sram_en   <= 1'b0;
         sram_r_wb <= 1'b1;
         sram_ad   <= '0;
         sram_di   <= '0;
         sram_ben  <= '0;
         c1_id     <= REQ_A;
         c1_we     <= 1'b0;
         c2_valid  <= 1'b0;
         c2_id     <= REQ_A;
         c2_we     <= 1'b0;
      end else begin
         sram_en  <= |grant;
         c2_valid <= sram_en;
         c2_id    <= c1_id;
         c2_we    <= c1_we;
         if (|grant) begin
            sram_r_wb <= ~c0_cmd.we;
            sram_ad   <= c0_cmd.addr;
            sram_di   <= c0_cmd.wdata;
            sram_ben  <= c0_cmd.we ? c0_cmd.ben : '0;
            c1_id     <= c0_cmd.id;
            c1_we     <= c0_cmd.we;
         end else begin
            // Idle: park in read mode, address and data hold.
            sram_r_wb <= 1'b1;
         end
      end
   end

   // Response demux: the non-target side and write acks return zero data.
   assign a_rsp_valid = c2_valid && (c2_id == REQ_A);
   assign b_rsp_valid = c2_valid && (c2_id == REQ_B);
   assign a_rsp_rdata = (a_rsp_valid && !c2_we) ? sram_do : '0;
   assign b_rsp_rdata = (b_rsp_valid && !c2_we) ? sram_do : '0;

endmodule

// File: tb/tb_ef_sram_arbiter.sv
module tb_ef_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (round-robin) ----------------
  logic          a_valid, a_ready, a_we, a_rsp_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_ben, a_rsp_rdata;
  logic          b_valid, b_ready, b_we, b_rsp_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_ben, b_rsp_rdata;
  logic [DW-1:0] sram_di, sram_ben, sram_do;
  logic [AW-1:0] sram_ad;
  logic          sram_en, sram_r_wb;

  ef_sram_arbiter #(.MAX_BURST(4), .PRIO_A(1'b0)) u_dut (
    .UserCLK(clk), .RST(rst),
    .a_req_valid(a_valid), .a_req_ready(a_ready), .a_req_we(a_we),
    .a_req_addr(a_addr), .a_req_wdata(a_wdata), .a_req_ben(a_ben),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_valid), .b_req_ready(b_ready), .b_req_we(b_we),
    .b_req_addr(b_addr), .b_req_wdata(b_wdata), .b_req_ben(b_ben),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_di(sram_di), .sram_ben(sram_ben), .sram_ad(sram_ad),
    .sram_en(sram_en), .sram_r_wb(sram_r_wb), .sram_do(sram_do)
  );

  // ---------------- second instance (fixed priority to A) ----------------
  logic          pa_a_valid, pa_a_ready, pa_a_rsp_valid;
  logic          pa_b_valid, pa_b_ready, pa_b_rsp_valid;
  logic [DW-1:0] pa_a_rsp_rdata, pa_b_rsp_rdata;
  logic [DW-1:0] pa_sram_di, pa_sram_ben;
  logic [AW-1:0] pa_sram_ad;
  logic          pa_sram_en, pa_sram_r_wb;
  logic          pa_zero_bit = 1'b0;
  logic [AW-1:0] pa_zero_addr = '0;
  logic [DW-1:0] pa_zero_data = '0;

  ef_sram_arbiter #(.MAX_BURST(4), .PRIO_A(1'b1)) u_pa (
    .UserCLK(clk), .RST(rst),
    .a_req_valid(pa_a_valid), .a_req_ready(pa_a_ready), .a_req_we(pa_zero_bit),
    .a_req_addr(pa_zero_addr), .a_req_wdata(pa_zero_data), .a_req_ben(pa_zero_data),
    .a_rsp_valid(pa_a_rsp_valid), .a_rsp_rdata(pa_a_rsp_rdata),
    .b_req_valid(pa_b_valid), .b_req_ready(pa_b_ready), .b_req_we(pa_zero_bit),
    .b_req_addr(pa_zero_addr), .b_req_wdata(pa_zero_data), .b_req_ben(pa_zero_data),
    .b_rsp_valid(pa_b_rsp_valid), .b_rsp_rdata(pa_b_rsp_rdata),
    .sram_di(pa_sram_di), .sram_ben(pa_sram_ben), .sram_ad(pa_sram_ad),
    .sram_en(pa_sram_en), .sram_r_wb(pa_sram_r_wb), .sram_do(pa_zero_data)
  );

  // ---------------- SRAM behavioural model ----------------
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (sram_en) begin
      if (!sram_r_wb) mem[sram_ad] <= (mem[sram_ad] & ~sram_ben) | (sram_di & sram_ben);
      else            sram_do <= mem[sram_ad];
    end
  end

  // ---------------- check task ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];   // {id, rdata}
  int            cyc_q[$];   // cycle the response is due
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW:0]   sb_exp, sb_got;
  int            sb_cyc;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
    end else begin
      if (a_rsp_valid || b_rsp_valid) begin
        check("rsp_single", {a_rsp_valid, b_rsp_valid} == 2'b11, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {a_rsp_valid, b_rsp_valid}, 0);
        end else begin
          sb_exp = exp_q.pop_front();
          sb_cyc = cyc_q.pop_front();
          sb_got = a_rsp_valid ? {1'b0, a_rsp_rdata} : {1'b1, b_rsp_rdata};
          check("rsp_id_data", sb_got, sb_exp);
          check("rsp_latency", cyc, sb_cyc);
          check("rsp_other_zero", a_rsp_valid ? b_rsp_rdata : a_rsp_rdata, 0);
        end
      end
      check("ready_onehot", a_ready & b_ready, 0);
      check("ready_wo_valid", (a_ready & ~a_valid) | (b_ready & ~b_valid), 0);
      if (a_valid && a_ready) begin
        exp_q.push_back({1'b0, a_we ? 32'h0 : ref_mem[a_addr]});
        cyc_q.push_back(cyc + 2);
        if (a_we) ref_mem[a_addr] = (ref_mem[a_addr] & ~a_ben) | (a_wdata & a_ben);
      end
      if (b_valid && b_ready) begin
        exp_q.push_back({1'b1, b_we ? 32'h0 : ref_mem[b_addr]});
        cyc_q.push_back(cyc + 2);
        if (b_we) ref_mem[b_addr] = (ref_mem[b_addr] & ~b_ben) | (b_wdata & b_ben);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic id, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] ben,
                      output int acc_cyc);
    bit ok = 0;
    acc_cyc = -1;
    if (id == 1'b0) begin
      a_valid = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_ben = ben;
    end else begin
      b_valid = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_ben = ben;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && a_ready) || (id == 1'b1 && b_ready)) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    @(posedge clk); #1;
    if (id == 1'b0) a_valid = 0; else b_valid = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int c0, c1, c2, ka, kb, first_b;
  bit took_a, took_b;

  initial begin
    rst = 1;
    a_valid = 1; a_we = 0; a_addr = '0; a_wdata = '0; a_ben = '0;
    b_valid = 1; b_we = 0; b_addr = '0; b_wdata = '0; b_ben = '0;
    pa_a_valid = 1; pa_b_valid = 1;

    // Reset with both valid
    repeat (2) begin
      @(negedge clk);
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_sram_en", sram_en, 0);
      check("rst_r_wb", sram_r_wb, 1);
      check("rst_ad", sram_ad, 0);
      check("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      check("rst_rdata", a_rsp_rdata | b_rsp_rdata, 0);
      check("rst_pa_ready", {pa_a_ready, pa_b_ready}, 0);
    end
    @(posedge clk); #1;
    rst = 0; a_valid = 0; b_valid = 0;

    // Fixed priority + burst limit: AAAAB repeating
    first_b = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("pa_one_grant", pa_a_ready ^ pa_b_ready, 1);
      check("pa_grant_b", pa_b_ready, (k % 5) == 4);
      if (pa_b_ready && first_b < 0) first_b = k;
    end
    check("pa_first_b", first_b, 4);
    @(posedge clk); #1;
    pa_a_valid = 0; pa_b_valid = 0;

    // A-only write, then read
    send(0, 1, 10'h3FF, 32'hDEADBEEF, 32'hFFFFFFFF, c0);
    @(negedge clk);
    check("wr_en", sram_en, 1);
    check("wr_r_wb", sram_r_wb, 0);
    check("wr_ad", sram_ad, 10'h3FF);
    check("wr_di", sram_di, 32'hDEADBEEF);
    check("wr_ben", sram_ben, 32'hFFFFFFFF);
    @(negedge clk);
    check("wr_rsp_valid", a_rsp_valid, 1);
    check("wr_rsp_rdata", a_rsp_rdata, 0);
    send(0, 0, 10'h3FF, 32'h0, 32'h0, c0);
    @(negedge clk);
    check("rd_en", sram_en, 1);
    check("rd_r_wb", sram_r_wb, 1);
    check("rd_ben", sram_ben, 0);
    @(negedge clk);
    check("rd_rsp_valid", a_rsp_valid, 1);
    check("rd_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);

    // Bit-enable write, back-to-back read
    send(0, 1, 10'h055, 32'hFFFFFFFF, 32'hFFFFFFFF, c0);
    send(0, 1, 10'h055, 32'h00000000, 32'h0000FF00, c1);
    send(0, 0, 10'h055, 32'h0, 32'h0, c2);
    check("b2b_wr", c1 - c0, 1);
    check("b2b_rd", c2 - c1, 1);
    @(negedge clk);
    @(negedge clk);
    check("ben_rsp_valid", a_rsp_valid, 1);
    check("ben_rsp_rdata", a_rsp_rdata, 32'hFFFF00FF);
    @(negedge clk);
    check("idle_en", sram_en, 0);
    check("idle_r_wb", sram_r_wb, 1);
    check("idle_ad_hold", sram_ad, 10'h055);

    // Preload for contention reads (A at 0..7, B at 0x200..0x207)
    for (int i = 0; i < 8; i++) begin
      send(0, 1, AW'(i), $urandom, 32'hFFFFFFFF, c0);
      send(1, 1, AW'(10'h200 + i), $urandom, $urandom_range(1, 32'hFFFF) | 32'hFFFF0000, c0);
    end

    // Contention, round-robin: last grant was B, so A first, then alternate
    ka = 0; kb = 0;
    a_valid = 1; a_we = 0; a_addr = 10'h000; a_ben = '0;
    b_valid = 1; b_we = 0; b_addr = 10'h200; b_ben = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      took_a = a_ready; took_b = b_ready;
      check("rr_alt_b", b_ready, (k % 2) == 1);
      if (took_a) ka++;
      if (took_b) kb++;
      @(posedge clk); #1;
      if (took_a) a_addr = AW'((a_addr + 1) % 8);
      if (took_b) b_addr = AW'(10'h200 + ((b_addr + 1) % 8));
    end
    a_valid = 0; b_valid = 0;
    check("rr_count_a", ka, 8);
    check("rr_count_b", kb, 8);
    repeat (4) @(negedge clk);

    // Mid-op reset: read accepted, reset in the next cycle, never answered
    @(posedge clk); #1;
    send(0, 0, 10'h3FF, 32'h0, 32'h0, c0);
    rst = 1;
    @(negedge clk);
    check("mid_cmd_on_pins", sram_en, 1);
    @(negedge clk);
    check("mid_en_dropped", sram_en, 0);
    check("mid_no_rsp", a_rsp_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_late_rsp", a_rsp_valid | b_rsp_valid, 0);
    end

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
